aidan_mcnay_div_arbiter: RTL and testbench

Shares one aidan_mcnay_itr_div instance between two independent requesters, for example two prime-detector FSMs or a detector plus a debug port.
- Each requester sees its own val/rdy operand stream and val/rdy result stream.
- The arbiter grants requesters round-robin, latches the operands, sequences the divider handshakes and routes the result back to the owner.
- Exactly one transaction is in flight at a time.

---
 rtl/aidan_mcnay_div_arbiter_pkg.sv | 13 +
 rtl/aidan_mcnay_rr_arb2.sv | 28 ++
 rtl/aidan_mcnay_div_arbiter.sv | 125 ++++++++++++
 tb/tb_aidan_mcnay_div_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aidan_mcnay_div_arbiter_pkg.sv
// Shared types for the two-requester divider arbiter.
package aidan_mcnay_div_arbiter_pkg;

  localparam int NREQ = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/aidan_mcnay_rr_arb2.sv
// Two-way round-robin grant: combinational grant, registered priority pointer.
// The pointer moves to the requester that was not just served when adv_i is strobed.
module aidan_mcnay_rr_arb2 (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] val_i,
  input  logic       adv_i,
  input  logic       last_i,
  output logic       gnt_vld_o,
  output logic       gnt_idx_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) ptr_d = ~last_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) ptr_q <= 1'b0;
    else          ptr_q <= ptr_d;
  end

  assign gnt_vld_o = |val_i;
  assign gnt_idx_o = (val_i == 2'b11) ? ptr_q : val_i[1];

endmodule

// File: rtl/aidan_mcnay_div_arbiter.sv
// Shares one iterative divider between two val/rdy requesters, one transaction in flight.
// Operands are latched at grant, so requesters may change them freely once accepted.
module aidan_mcnay_div_arbiter
  import aidan_mcnay_div_arbiter_pkg::*;
#(
  parameter int nbits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [nbits-1:0] req0_opa,
  input  logic [nbits-1:0] req0_opb,
  input  logic             req0_istream_val,
  output logic             req0_istream_rdy,
  output logic [nbits-1:0] req0_result,
  output logic             req0_ostream_val,
  input  logic             req0_ostream_rdy,
  input  logic [nbits-1:0] req1_opa,
  input  logic [nbits-1:0] req1_opb,
  input  logic             req1_istream_val,
  output logic             req1_istream_rdy,
  output logic [nbits-1:0] req1_result,
  output logic             req1_ostream_val,
  input  logic             req1_ostream_rdy,
  output logic [nbits-1:0] div_opa,
  output logic [nbits-1:0] div_opb,
  output logic             div_istream_val,
  input  logic             div_istream_rdy,
  input  logic [nbits-1:0] div_result,
  input  logic             div_ostream_val,
  output logic             div_ostream_rdy
);

  arb_state_e       state_q, state_d;
  logic             owner_q, owner_d;
  logic [nbits-1:0] opa_q, opa_d;
  logic [nbits-1:0] opb_q, opb_d;
  logic [nbits-1:0] result_q, result_d;

  logic [NREQ-1:0]  istream_rdy;
  logic [NREQ-1:0]  ostream_val;
  logic [NREQ-1:0]  ostream_rdy;
  logic             gnt_vld, gnt_idx, adv;

  assign ostream_rdy = {req1_ostream_rdy, req0_ostream_rdy};

  aidan_mcnay_rr_arb2 u_rr (
    .clk_i     (clk),
    .reset_i   (reset),
    .val_i     ({req1_istream_val, req0_istream_val}),
    .adv_i     (adv),
    .last_i    (owner_q),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    opa_d           = opa_q;
    opb_d           = opb_q;
    result_d        = result_q;
    istream_rdy     = '0;
    ostream_val     = '0;
    div_istream_val = 1'b0;
    div_ostream_rdy = 1'b0;
    adv             = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by reset so no requester sees an accept while reset is held.
        if (reset && gnt_vld) begin
          istream_rdy[gnt_idx] = 1'b1;
          owner_d              = gnt_idx;
          opa_d                = gnt_idx ? req1_opa : req0_opa;
          opb_d                = gnt_idx ? req1_opb : req0_opb;
          state_d              = ISSUE;
        end
      end
      ISSUE: begin
        div_istream_val = 1'b1;
        if (div_istream_rdy) state_d = WAIT;
      end
      WAIT: begin
        div_ostream_rdy = 1'b1;
        if (div_ostream_val) begin
          result_d = div_result;
          state_d  = RESP;
        end
      end
      RESP: begin
        ostream_val[owner_q] = 1'b1;
        if (ostream_rdy[owner_q]) begin
          adv     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
    end
  end

  assign req0_istream_rdy = istream_rdy[0];
  assign req1_istream_rdy = istream_rdy[1];
  assign req0_ostream_val = ostream_val[0];
  assign req1_ostream_val = ostream_val[1];
  assign req0_result      = result_q;
  assign req1_result      = result_q;
  assign div_opa          = opa_q;
  assign div_opb          = opb_q;

endmodule

// File: tb/tb_aidan_mcnay_div_arbiter.sv
// Randomized scoreboard bench for the divider arbiter with a behavioural divider model.
module tb_aidan_mcnay_div_arbiter;
  localparam int NB = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NB-1:0] req0_opa = '0, req0_opb = '0, req1_opa = '0, req1_opb = '0;
  logic          req0_istream_val = 1'b0, req1_istream_val = 1'b0;
  logic          req0_ostream_rdy = 1'b0, req1_ostream_rdy = 1'b0;
  logic          req0_istream_rdy, req1_istream_rdy, req0_ostream_val, req1_ostream_val;
  logic [NB-1:0] req0_result, req1_result, div_opa, div_opb;
  logic          div_istream_val, div_ostream_rdy;
  logic          div_istream_rdy = 1'b0, div_ostream_val = 1'b0;
  logic [NB-1:0] div_result = '0;

  always #5 clk = ~clk;

  aidan_mcnay_div_arbiter #(.nbits(NB)) dut (
    .clk(clk), .reset(reset),
    .req0_opa(req0_opa), .req0_opb(req0_opb), .req0_istream_val(req0_istream_val),
    .req0_istream_rdy(req0_istream_rdy), .req0_result(req0_result),
    .req0_ostream_val(req0_ostream_val), .req0_ostream_rdy(req0_ostream_rdy),
    .req1_opa(req1_opa), .req1_opb(req1_opb), .req1_istream_val(req1_istream_val),
    .req1_istream_rdy(req1_istream_rdy), .req1_result(req1_result),
    .req1_ostream_val(req1_ostream_val), .req1_ostream_rdy(req1_ostream_rdy),
    .div_opa(div_opa), .div_opb(div_opb), .div_istream_val(div_istream_val),
    .div_istream_rdy(div_istream_rdy), .div_result(div_result),
    .div_ostream_val(div_ostream_val), .div_ostream_rdy(div_ostream_rdy)
  );

  int n_cmp = 0, n_err = 0;
  int cyc = 0, acc_cyc = 0, n_done = 0, rst_cnt = 0;
  // Knobs steering the requesters and the divider model.
  int gen_pct = 0, rsp_pct = 100, div_rdy_pct = 100, dv_lat_min = 0, dv_lat_max = 0, div_stall = 0;
  bit cont = 0, bp0 = 0, bp1 = 0, garbage_en = 0, poke55 = 0, lat_chk = 0;
  logic [NB-1:0] dir_a0[$], dir_b0[$], dir_a1[$], dir_b1[$];
  // Reference model state.
  logic [NB-1:0] exp_q0[$], exp_q1[$];
  logic [NB-1:0] inf_opa = '0, inf_opb = '0;
  bit inflight = 0, done_any = 0, last_owner = 0, expect_grant = 0, seen_rsp = 0;
  bit drop0 = 0, drop1 = 0;
  int dv_state = 0, dv_cnt = 0;
  logic [NB-1:0] dv_res = '0;

  function automatic logic [NB-1:0] ref_div(input logic [NB-1:0] a, input logic [NB-1:0] b);
    return (b == '0) ? '1 : a / b;
  endfunction

  function automatic logic [NB-1:0] rand_divisor();
    return ($urandom_range(7) == 0) ? '0 : NB'($urandom_range(1000));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ctl"}, {req0_istream_rdy, req1_istream_rdy, req0_ostream_val,
                          req1_ostream_val, div_istream_val, div_ostream_rdy}, 0);
    check({tag, "_ops"}, {div_opa, div_opb}, 0);
    check({tag, "_res"}, {req0_result, req1_result}, 0);
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    reset = (rst_cnt == 0);
    if (rst_cnt > 0) rst_cnt--;
    if (drop0) begin req0_istream_val = 1'b0; drop0 = 0; end
    if (drop1) begin req1_istream_val = 1'b0; drop1 = 0; end
    if (!reset) begin
      req0_istream_val = 1'b0;
      req1_istream_val = 1'b0;
    end else begin
      if (!req0_istream_val) begin
        if (dir_a0.size() > 0) begin
          req0_opa = dir_a0.pop_front(); req0_opb = dir_b0.pop_front(); req0_istream_val = 1'b1;
        end else if (cont || $urandom_range(99) < gen_pct) begin
          req0_opa = $urandom; req0_opb = rand_divisor(); req0_istream_val = 1'b1;
        end else req0_opa = poke55 ? NB'(55) : NB'($urandom);
      end
      if (!req1_istream_val) begin
        if (dir_a1.size() > 0) begin
          req1_opa = dir_a1.pop_front(); req1_opb = dir_b1.pop_front(); req1_istream_val = 1'b1;
        end else if (cont || $urandom_range(99) < gen_pct) begin
          req1_opa = $urandom; req1_opb = rand_divisor(); req1_istream_val = 1'b1;
        end else req1_opa = $urandom;
      end
    end
    req0_ostream_rdy = !bp0 && ($urandom_range(99) < rsp_pct);
    req1_ostream_rdy = !bp1 && ($urandom_range(99) < rsp_pct);
    case (dv_state)
      0: begin
        div_istream_rdy = (div_stall == 0) && ($urandom_range(99) < div_rdy_pct);
        div_ostream_val = garbage_en && ($urandom_range(3) == 0);
        div_result      = $urandom;
      end
      1: begin
        div_istream_rdy = 1'b0;
        if (dv_cnt == 0) begin
          dv_state = 2; div_ostream_val = 1'b1; div_result = dv_res;
        end else begin
          dv_cnt--; div_ostream_val = 1'b0;
        end
      end
      default: begin
        div_istream_rdy = 1'b0; div_ostream_val = 1'b1; div_result = dv_res;
      end
    endcase
    #1;
    if (reset) begin
      if (expect_grant)
        check("grant_after_resp", req0_istream_val && req0_istream_rdy ||
                                  req1_istream_val && req1_istream_rdy, 1);
      expect_grant = 0;
      if ((req0_istream_val && req0_istream_rdy) || (req1_istream_val && req1_istream_rdy)) begin
        check("dual_grant", req0_istream_rdy && req1_istream_rdy, 0);
        check("one_in_flight", inflight, 0);
        if (req0_istream_val && req1_istream_val)
          check("rr_grant", req1_istream_rdy, done_any ? !last_owner : 1'b0);
        if (req1_istream_rdy) begin
          exp_q1.push_back(ref_div(req1_opa, req1_opb));
          inf_opa = req1_opa; inf_opb = req1_opb; drop1 = 1;
        end else begin
          exp_q0.push_back(ref_div(req0_opa, req0_opb));
          inf_opa = req0_opa; inf_opb = req0_opb; drop0 = 1;
        end
        inflight = 1; acc_cyc = cyc; seen_rsp = 0;
      end
      if (div_istream_val && div_istream_rdy) begin
        dv_res = ref_div(div_opa, div_opb);
        dv_state = 1;
        dv_cnt = $urandom_range(dv_lat_max, dv_lat_min);
      end else if (div_istream_val && div_stall > 0) div_stall--;
      if (dv_state == 2 && div_ostream_rdy) dv_state = 0;
    end else begin
      exp_q0.delete(); exp_q1.delete();
      inflight = 0; done_any = 0; expect_grant = 0; dv_state = 0; drop0 = 0; drop1 = 0;
    end
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while ((inflight || exp_q0.size() > 0 || exp_q1.size() > 0 || req0_istream_val ||
            req1_istream_val || dir_a0.size() > 0 || dir_a1.size() > 0) && n < limit) begin
      step();
      n++;
    end
    check(tag, n < limit, 1);
  endtask

  // Monitor: compares every presented result against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        check("both_ostream_val", req0_ostream_val && req1_ostream_val, 0);
        if (div_istream_val) begin
          check("div_opa", div_opa, inf_opa);
          check("div_opb", div_opb, inf_opb);
        end
        if (req0_ostream_val || req1_ostream_val) begin
          if ((req0_ostream_val && exp_q0.size() == 0) || (req1_ostream_val && exp_q1.size() == 0)) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_rsp: got val0=%0b val1=%0b expected no response (cycle %0d)",
                     req0_ostream_val, req1_ostream_val, cyc);
          end else begin
            if (req0_ostream_val) check("rsp0", req0_result, exp_q0[0]);
            else                  check("rsp1", req1_result, exp_q1[0]);
            if (!seen_rsp) begin
              seen_rsp = 1;
              if (lat_chk) check("latency", cyc - acc_cyc, 3);
            end
            if ((req0_ostream_val && req0_ostream_rdy) || (req1_ostream_val && req1_ostream_rdy)) begin
              last_owner = req1_ostream_val;
              if (req0_ostream_val) void'(exp_q0.pop_front());
              else                  void'(exp_q1.pop_front());
              inflight = 0; done_any = 1; n_done++;
              expect_grant = req0_istream_val || req1_istream_val;
            end
          end
        end
      end
    end
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: got no finish expected finish before 50000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    rst_cnt = 3;
    step(); step();
    check_idle("reset");
    step();

    // Single request, immediate divider: 3-cycle result latency.
    lat_chk = 1;
    dir_a0.push_back(91); dir_b0.push_back(7);
    wait_done("t1_done", 50);
    lat_chk = 0;

    // Simultaneous pair after reset starts with req0; pointer then alternates.
    rst_cnt = 1; step();
    dir_a0.push_back(97); dir_b0.push_back(3); dir_a1.push_back(100); dir_b1.push_back(10);
    wait_done("t2_pair", 60);
    dir_a0.push_back(8); dir_b0.push_back(2);
    wait_done("t2_single", 40);
    dir_a0.push_back(20); dir_b0.push_back(4); dir_a1.push_back(30); dir_b1.push_back(5);
    wait_done("t2_pair2", 60);

    // Result backpressure on req1 while req0 waits.
    bp1 = 1;
    dir_a1.push_back(40); dir_b1.push_back(5);
    n = 0;
    while (!req1_ostream_val && n < 30) begin step(); n++; end
    check("t3_reach_resp", req1_ostream_val, 1);
    dir_a0.push_back(60); dir_b0.push_back(6);
    repeat (10) begin
      step();
      check("t3_no_grant", req0_istream_rdy, 0);
    end
    bp1 = 0;
    wait_done("t3_done", 60);

    // Divider refuses operands for 5 cycles while req0 scribbles on opa.
    div_stall = 5; poke55 = 1;
    dir_a0.push_back(123); dir_b0.push_back(4);
    wait_done("t4_done", 60);
    poke55 = 0;
    check("t4_stall_used", div_stall, 0);

    // Reset while waiting on a slow divider.
    dv_lat_min = 20; dv_lat_max = 20;
    dir_a1.push_back(77); dir_b1.push_back(7);
    n = 0;
    while (!div_ostream_rdy && n < 20) begin step(); n++; end
    check("t5_reach_wait", div_ostream_rdy, 1);
    rst_cnt = 1; step(); step();
    check_idle("t5_post_rst");
    garbage_en = 1;
    repeat (4) begin step(); check_idle("t5_ignore_div"); end
    garbage_en = 0; dv_lat_min = 0; dv_lat_max = 0;
    dir_a1.push_back(81); dir_b1.push_back(9);
    wait_done("t5_next", 40);

    // Continuous contention for 8 transactions.
    cont = 1; base = n_done; n = 0;
    while (n_done - base < 8 && n < 200) begin step(); n++; end
    check("t6_eight_done", n_done - base >= 8, 1);
    cont = 0;
    wait_done("t6_drain", 80);

    // Random traffic with divider jitter and stray divider valids.
    gen_pct = 35; rsp_pct = 60; div_rdy_pct = 50; dv_lat_max = 3; garbage_en = 1;
    repeat (400) step();
    gen_pct = 0; rsp_pct = 100; div_rdy_pct = 100; garbage_en = 0;
    wait_done("final_drain", 300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
